// File: rtl/mux_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mux_sched_if                                           |
// | Description : Producer/consumer bundle for the N:1 channel mux.      |
// |               master = environment side, slave = mux side.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mux_sched_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) ();
  logic [N*WIDTH-1:0] a;     // channel data, channel i at [i*WIDTH +: WIDTH]
  logic [N-1:0]       av;    // channel valid
  logic [N-1:0]       ar;    // channel ready, one-hot or zero
  logic [SELW-1:0]    s;     // manual select
  logic               mode;  // 0 = manual, 1 = round-robin
  logic [WIDTH-1:0]   y;     // registered output data
  logic               yv;    // output valid
  logic               yr;    // consumer ready
  logic [SELW-1:0]    ch;    // channel that produced y

  modport master (
    output a, av, s, mode, yr,
    input  ar, y, yv, ch
  );

  modport slave (
    input  a, av, s, mode, yr,
    output ar, y, yv, ch
  );
endinterface
`default_nettype wire

// File: rtl/mux_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mux_sched                                              |
// | Description : Registered N:1 valid/ready channel mux with manual     |
// |               select or round-robin scheduling, one output entry.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mux_sched #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mux_sched_if.slave    bus_if
);

  localparam logic [SELW-1:0] c_LAST = SELW'(N - 1);

  // Output entry and round-robin pointer
  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             yv_q, yv_d;
  logic [SELW-1:0]  p_q, p_d;

  // Grant logic
  logic             w_le;
  logic             w_s_av;
  logic             w_hit_hi, w_hit_lo;
  logic [SELW-1:0]  w_idx_hi, w_idx_lo;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;

  // The entry can take a new word when empty or when its word leaves now.
  assign w_le = !yv_q | bus_if.yr;

  // Manual mode: valid of the selected channel; an out-of-range select
  // matches no channel and so never grants.
  always_comb begin
    w_s_av = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == bus_if.s) w_s_av = bus_if.av[i];
    end
  end

  // Round-robin: first requester at or above p, otherwise first requester
  // overall (which then necessarily lies below p, giving the wrap).
  always_comb begin
    w_hit_hi = 1'b0;
    w_idx_hi = '0;
    w_hit_lo = 1'b0;
    w_idx_lo = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_hit_hi && bus_if.av[i] && (SELW'(i) >= p_q)) begin
        w_hit_hi = 1'b1;
        w_idx_hi = SELW'(i);
      end
      if (!w_hit_lo && bus_if.av[i]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = SELW'(i);
      end
    end
  end

  assign w_gnt_vld = bus_if.mode ? (w_hit_hi | w_hit_lo) : w_s_av;
  assign w_gnt     = bus_if.mode ? (w_hit_hi ? w_idx_hi : w_idx_lo) : bus_if.s;

  // Reset blocks any transfer, so ready is withheld while it is asserted.
  assign w_xfer = w_gnt_vld & w_le & !rst;

  // Data of the granted channel
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == w_gnt) w_gnt_data = bus_if.a[i*WIDTH +: WIDTH];
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ar
      assign bus_if.ar[gi] = w_xfer & (w_gnt == SELW'(gi));
    end
  endgenerate

  // Next-state for the output entry and the pointer
  always_comb begin
    y_d  = y_q;
    ch_d = ch_q;
    yv_d = yv_q;
    p_d  = p_q;
    if (w_xfer) begin
      y_d  = w_gnt_data;
      ch_d = w_gnt;
      yv_d = 1'b1;
      if (bus_if.mode) p_d = (w_gnt == c_LAST) ? '0 : w_gnt + SELW'(1);
    end else if (yv_q && bus_if.yr) begin
      yv_d = 1'b0;
    end
  end

  // State registers; reset discards any held word and any same-cycle load
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q  <= '0;
      ch_q <= '0;
      yv_q <= 1'b0;
      p_q  <= '0;
    end else begin
      y_q  <= y_d;
      ch_q <= ch_d;
      yv_q <= yv_d;
      p_q  <= p_d;
    end
  end

  assign bus_if.y  = y_q;
  assign bus_if.ch = ch_q;
  assign bus_if.yv = yv_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mux_sched                                           |
// | Description : Directed vector bench for mux_sched (N=4, WIDTH=8).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mux_sched;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux_sched_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus_if ();

  mux_sched #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [3:0]  av;
    logic [31:0] a;
    logic        yr;
    logic [3:0]  ar;   // expected ready before the edge
    logic [7:0]  y;    // expected after the edge
    logic        yv;
    logic [1:0]  ch;
  } vec_t;

  localparam logic [31:0] c_A_DEF = 32'h1312_1110;

  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] av,
                              logic [31:0] a, logic yr, logic [3:0] ar,
                              logic [7:0] y, logic yv, logic [1:0] ch);
    vec_t v;
    v.rst = r; v.mode = m; v.s = s; v.av = av; v.a = a; v.yr = yr;
    v.ar = ar; v.y = y; v.yv = yv; v.ch = ch;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check ready before the edge, check the entry after it.
  task automatic step(input vec_t v, input string tag);
    rst         = v.rst;
    bus_if.mode = v.mode;
    bus_if.s    = v.s;
    bus_if.av   = v.av;
    bus_if.a    = v.a;
    bus_if.yr   = v.yr;
    #2;
    chk({tag, ".ar"}, 32'(bus_if.ar), 32'(v.ar));
    @(posedge clk);
    #1;
    chk({tag, ".y"},  32'(bus_if.y),  32'(v.y));
    chk({tag, ".yv"}, 32'(bus_if.yv), 32'(v.yv));
    chk({tag, ".ch"}, 32'(bus_if.ch), 32'(v.ch));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    //               rst m  s    av       a              yr ar       y      yv ch
    // reset with all channels requesting
    vecs[0]  = mk(1, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0000, 8'h00, 0, 0);
    vecs[1]  = mk(1, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0000, 8'h00, 0, 0);
    // manual select of channel 2, then select 3 with only 2 requesting
    vecs[2]  = mk(0, 0, 2, 4'b0100, 32'h13A5_1110, 1, 4'b0100, 8'hA5, 1, 2);
    vecs[3]  = mk(0, 0, 3, 4'b0100, 32'h13A5_1110, 1, 4'b0000, 8'hA5, 0, 2);
    // round-robin fairness from p=0
    vecs[4]  = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0001, 8'h10, 1, 0);
    vecs[5]  = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0010, 8'h11, 1, 1);
    vecs[6]  = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0100, 8'h12, 1, 2);
    vecs[7]  = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b1000, 8'h13, 1, 3);
    vecs[8]  = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0001, 8'h10, 1, 0);
    // reset to p=0, then skip-and-wrap with channels 0 and 3
    vecs[9]  = mk(1, 1, 0, 4'b1001, c_A_DEF,       1, 4'b0000, 8'h00, 0, 0);
    vecs[10] = mk(0, 1, 0, 4'b1001, c_A_DEF,       1, 4'b0001, 8'h10, 1, 0);
    vecs[11] = mk(0, 1, 0, 4'b1001, c_A_DEF,       1, 4'b1000, 8'h13, 1, 3);
    vecs[12] = mk(0, 1, 0, 4'b1001, c_A_DEF,       1, 4'b0001, 8'h10, 1, 0);
    // backpressure: load 3C, stall 5 cycles, then accept and reload together
    vecs[13] = mk(0, 0, 1, 4'b0010, 32'h1312_3C10, 1, 4'b0010, 8'h3C, 1, 1);
    vecs[14] = mk(0, 0, 1, 4'b0010, 32'h1312_3C10, 0, 4'b0000, 8'h3C, 1, 1);
    vecs[15] = mk(0, 1, 1, 4'b0010, 32'h1312_3C10, 0, 4'b0000, 8'h3C, 1, 1);
    vecs[16] = mk(0, 0, 2, 4'b0110, 32'h1312_3C10, 0, 4'b0000, 8'h3C, 1, 1);
    vecs[17] = mk(0, 1, 3, 4'b1111, 32'h1312_3C10, 0, 4'b0000, 8'h3C, 1, 1);
    vecs[18] = mk(0, 0, 1, 4'b0010, 32'h1312_3C10, 0, 4'b0000, 8'h3C, 1, 1);
    vecs[19] = mk(0, 0, 2, 4'b0100, 32'h1355_3C10, 1, 4'b0100, 8'h55, 1, 2);
    // stall, reset mid-stall, then round-robin restarts at channel 0
    vecs[20] = mk(0, 1, 0, 4'b1111, c_A_DEF,       0, 4'b0000, 8'h55, 1, 2);
    vecs[21] = mk(1, 1, 0, 4'b1111, c_A_DEF,       0, 4'b0000, 8'h00, 0, 0);
    vecs[22] = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0001, 8'h10, 1, 0);
    vecs[23] = mk(0, 1, 0, 4'b1111, c_A_DEF,       1, 4'b0010, 8'h11, 1, 1);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Pointer is now 2; a manual transfer must not move it.
    step(mk(0, 0, 0, 4'b0001, c_A_DEF, 1, 4'b0001, 8'h10, 1, 0), "m0_keep_p");
    step(mk(0, 1, 0, 4'b1111, c_A_DEF, 1, 4'b0100, 8'h12, 1, 2), "rr_after_m0");
    // Idle drain: accept with nothing requesting clears valid, data holds.
    step(mk(0, 1, 0, 4'b0000, c_A_DEF, 1, 4'b0000, 8'h12, 0, 2), "drain");
    step(mk(0, 1, 0, 4'b0000, c_A_DEF, 0, 4'b0000, 8'h12, 0, 2), "idle");
    // Empty entry loads even with consumer not ready; p=3 so channel 3 wins.
    step(mk(0, 1, 0, 4'b1010, c_A_DEF, 0, 4'b1000, 8'h13, 1, 3), "load_yr0");
    step(mk(0, 1, 0, 4'b1010, c_A_DEF, 1, 4'b0010, 8'h11, 1, 1), "wrap_to_1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
